memory_bus_responder: RTL and testbench
=======================================

Name: memory_bus_responder

Overview:
- Memory-side responder for the CPU data/instruction bus.
- Consumes the chip selects RAM_CS, ROM_CS and RAM_WE produced by the system address decoder.
- Sequences synchronous ROM (0x0000–0x1FFF) and RAM (0x2000–0x2FFF) accesses with programmable wait states.
- Returns ReadData with a single-cycle Ready pulse, or flags BusErr for illegal accesses.

Parameters:
- ROM_WAIT, 2, extra wait cycles before a ROM access strobe (0–15)
- RAM_WAIT, 0, extra wait cycles before a RAM access strobe (0–15)
- RAM_BASE, 32'h2000, RAM base byte address subtracted to form ram_addr
- ROM_AW, 11, ROM word-address width (2048 words)
- RAM_AW, 10, RAM word-address width (1024 words)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Req  in  1  CPU request valid
- MemWrite  in  1  1 = write, 0 = read
- Addr  in  32  byte address
- WriteData  in  32  write data
- ByteEn  in  4  write byte lanes
- RAM_CS  in  1  from address decoder
- RAM_WE  in  1  from address decoder
- ROM_CS  in  1  from address decoder
- Ready  out  1  one-cycle completion pulse
- ReadData  out  32  registered read data
- BusErr  out  1  qualifies Ready: transaction failed
- rom_en  out  1  ROM read strobe
- rom_addr  out  ROM_AW  ROM word address
- rom_rdata  in  32  ROM data, valid one cycle after rom_en
- ram_en  out  1  RAM strobe
- ram_we  out  1  RAM write enable, valid with ram_en
- ram_be  out  4  RAM byte enables
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM data, valid one cycle after ram_en with ram_we=0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 (Ready, ReadData, BusErr, strobes, addresses, ram_wdata, ram_be); FSM in IDLE; wait counter 0.
- Reset mid-transaction:
  - The pending transaction is dropped and no Ready is issued.
  - No strobe may be asserted while rst_n=0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE, Req=1: latch Addr, WriteData, ByteEn, MemWrite, RAM_CS, RAM_WE, ROM_CS. Then evaluate in priority order:
  - (a) RAM_CS and ROM_CS both 1, or both 0 → RESP, error.
  - (b) ROM_CS and MemWrite=1 → RESP, error; ROM is never strobed.
  - (c) misaligned (see Optional Feature) → RESP, error.
  - (d) otherwise load counter with ROM_WAIT or RAM_WAIT; go WAIT if nonzero, else ACCESS.
- WAIT: decrement counter each cycle; on reaching 0 go ACCESS.
- ACCESS: assert exactly one cycle of strobe, then go RESP.
  - ROM: rom_en=1.
  - RAM read: ram_en=1, ram_we=0.
  - RAM write: ram_en=1, ram_we=RAM_WE, ram_be=ByteEn, ram_wdata=WriteData.
  - A RAM write with ByteEn=0 asserts no strobe but still completes normally.
- RESP: Ready=1 for exactly one cycle, then go IDLE.
  - Read: ReadData ← rom_rdata or ram_rdata; BusErr=0.
  - Write: ReadData holds its previous value; BusErr=0.
  - Error: ReadData ← 0; BusErr=1.
- Address arithmetic:
  - rom_addr = Addr[ROM_AW+1:2].
  - ram_addr = (Addr − RAM_BASE)[RAM_AW+1:2], modulo 2^RAM_AW.
- Latency, counted from the accepting edge to the Ready cycle: WAIT count + 2 cycles (RAM_WAIT=0 → 2; ROM_WAIT=2 → 4).
- Handshake:
  - Requester changes its request only after Ready.
  - Req and input changes during WAIT/ACCESS/RESP are ignored because fields are latched.
  - Req still high in the cycle after Ready is accepted as a new transaction (back-to-back, no bubble cycle).
- Ready and BusErr are never asserted outside RESP. Strobes are never asserted outside ACCESS.

Optional Feature:
- Macro MISALIGN_CHECK_EN.
- Defined: Addr[1:0]≠0 → error path (c); BusErr=1, no strobe.
- Undefined: Addr[1:0] ignored; access proceeds to the aligned word.

Decomposition:
- Package mem_bus_pkg:
  - FSM state encoding.
  - ROM_BASE=0, ROM_LIMIT=32'h2000, RAM_BASE=32'h2000, RAM_LIMIT=32'h3000.
  - Wait-counter width (4).
- One sub-module, wait_state_counter: loadable down-counter with async reset and a done flag, instantiated once.

Test Plan:
- RAM_WAIT=0, Req read at 0x2004, ram_rdata=0xDEADBEEF → ram_en with ram_addr=1 one cycle after accept; Ready=1, ReadData=0xDEADBEEF, BusErr=0 two cycles after accept.
- ROM_WAIT=2, read 0x0010, rom_rdata=0x12345678 → rom_addr=4; Ready 4 cycles after accept; ReadData=0x12345678.
- Write 0x2FFC, WriteData=0xA5A5A5A5, ByteEn=4'b0011, RAM_WE=1 → ram_we=1, ram_be=0011, ram_addr=0x3FF; Ready; ReadData unchanged.
- Write to ROM 0x0100, and separately read 0x4000 (both CS=0) → no strobe; Ready with BusErr=1, ReadData=0.
- Read at 0x2002 → with MISALIGN_CHECK_EN: BusErr=1; without: ram_addr=0, normal read.
- rst_n driven low during ROM WAIT, then released → no rom_en, no Ready; next request completes normally; back-to-back Req held high yields Ready on consecutive transactions with no bubble.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state encoding, memory map and wait-counter width for the memory bus responder
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT = 32'h0000_2000;
    localparam logic [31:0] RAM_BASE  = 32'h0000_2000;
    localparam logic [31:0] RAM_LIMIT = 32'h0000_3000;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/wait_state_counter.sv
// rtl/wait_state_counter.sv - loadable wait-state down-counter; done marks the final wait cycle
module wait_state_counter
    import mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    output logic              done
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WAIT_W'(1);
        end
    end

    // High while the count is 1, so the owner can launch its access on the edge that empties it.
    assign done = (count == WAIT_W'(1));

endmodule

// File: rtl/memory_bus_responder.sv
// rtl/memory_bus_responder.sv - ROM/RAM responder with programmable wait states; MISALIGN_CHECK_EN rejects unaligned addresses
module memory_bus_responder #(
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 0,
    parameter logic [31:0] RAM_BASE = mem_bus_pkg::RAM_BASE,
    parameter int unsigned ROM_AW   = 11,
    parameter int unsigned RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    input  logic [3:0]        ByteEn,
    input  logic              RAM_CS,
    input  logic              RAM_WE,
    input  logic              ROM_CS,
    output logic              Ready,
    output logic [31:0]       ReadData,
    output logic              BusErr,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    import mem_bus_pkg::*;

    state_t state;

    logic       rom_q;
    logic       write_q;
    logic       ram_we_q;
    logic [3:0] be_q;
    logic       err_q;
    logic [31:0] rdata_q;

    logic              cs_conflict;
    logic              rom_write;
    logic              misalign;
    logic              req_err;
    logic [WAIT_W-1:0] req_wait;
    logic [31:0]       ram_off;
    logic              accept;
    logic              wait_load;
    logic              wait_done;
    logic              fire;

    logic       acc_rom;
    logic       acc_write;
    logic       acc_we;
    logic [3:0] acc_be;
    logic [31:0] resp_data;

    assign cs_conflict = ~(RAM_CS ^ ROM_CS);
    assign rom_write   = ROM_CS & MemWrite;

`ifdef MISALIGN_CHECK_EN
    assign misalign = |Addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign req_err  = cs_conflict | rom_write | misalign;
    assign req_wait = ROM_CS ? WAIT_W'(ROM_WAIT) : WAIT_W'(RAM_WAIT);
    assign ram_off  = Addr - RAM_BASE;

    assign accept    = (state == ST_IDLE) && Req;
    assign wait_load = accept && !req_err;
    assign fire      = (wait_load && (req_wait == '0)) || ((state == ST_WAIT) && wait_done);

    wait_state_counter u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (wait_load),
        .load_value (req_wait),
        .done       (wait_done)
    );

    // Straight from the bus when launching out of IDLE, otherwise from the latched copy.
    always_comb begin
        acc_rom   = rom_q;
        acc_write = write_q;
        acc_we    = ram_we_q;
        acc_be    = be_q;
        if (state == ST_IDLE) begin
            acc_rom   = ROM_CS;
            acc_write = MemWrite;
            acc_we    = RAM_WE;
            acc_be    = ByteEn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rom_q     <= 1'b0;
            write_q   <= 1'b0;
            ram_we_q  <= 1'b0;
            be_q      <= 4'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            Ready     <= 1'b0;
            BusErr    <= 1'b0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_be    <= 4'b0;
            ram_addr  <= '0;
            ram_wdata <= 32'h0;
        end else begin
            Ready  <= 1'b0;
            BusErr <= 1'b0;
            rom_en <= fire & acc_rom;
            ram_en <= fire & ~acc_rom & ~(acc_write & (acc_be == 4'b0));
            ram_we <= fire & ~acc_rom & acc_write & acc_we & (acc_be != 4'b0);
            case (state)
                ST_IDLE: begin
                    if (Req) begin
                        rom_q     <= ROM_CS;
                        write_q   <= MemWrite;
                        ram_we_q  <= RAM_WE;
                        be_q      <= ByteEn;
                        err_q     <= req_err;
                        rom_addr  <= Addr[ROM_AW+1:2];
                        ram_addr  <= ram_off[RAM_AW+1:2];
                        ram_wdata <= WriteData;
                        ram_be    <= MemWrite ? ByteEn : 4'b0;
                        if (req_err) begin
                            state  <= ST_RESP;
                            Ready  <= 1'b1;
                            BusErr <= 1'b1;
                        end else if (req_wait != '0) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                    Ready <= 1'b1;
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    rdata_q <= resp_data;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory data only arrives in the RESP cycle, so it is forwarded then and held in rdata_q afterwards.
    assign resp_data = err_q   ? 32'h0 :
                       write_q ? rdata_q :
                       rom_q   ? rom_rdata : ram_rdata;
    assign ReadData  = (state == ST_RESP) ? resp_data : rdata_q;

    logic unused_bits;
    assign unused_bits = ^{Addr, ram_off};

endmodule

// File: tb/tb_memory_bus_responder.sv
// tb/tb_memory_bus_responder.sv - directed bench with a transaction-level timeline model checked every cycle
module tb_memory_bus_responder;

    localparam int ROM_WAIT = 2;
    localparam int RAM_WAIT = 0;
    localparam int DEPTH    = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Req;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic        RAM_CS;
    logic        RAM_WE;
    logic        ROM_CS;
    logic        Ready;
    logic [31:0] ReadData;
    logic        BusErr;
    logic        rom_en;
    logic [10:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    memory_bus_responder #(
        .ROM_WAIT (ROM_WAIT),
        .RAM_WAIT (RAM_WAIT),
        .RAM_BASE (32'h2000),
        .ROM_AW   (11),
        .RAM_AW   (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Req       (Req),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ByteEn    (ByteEn),
        .RAM_CS    (RAM_CS),
        .RAM_WE    (RAM_WE),
        .ROM_CS    (ROM_CS),
        .Ready     (Ready),
        .ReadData  (ReadData),
        .BusErr    (BusErr),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_be    (ram_be),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    bit          exp_ready [0:DEPTH-1];
    bit          exp_err   [0:DEPTH-1];
    bit          exp_rom   [0:DEPTH-1];
    bit          exp_ram   [0:DEPTH-1];
    bit          exp_we    [0:DEPTH-1];
    logic [31:0] exp_addr  [0:DEPTH-1];
    logic [3:0]  exp_be    [0:DEPTH-1];
    logic [31:0] exp_wd    [0:DEPTH-1];
    logic [31:0] exp_rd    [0:DEPTH-1];
    logic [31:0] model_last = 32'h0;
    logic [31:0] cur_rd     = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (!rst_n) cur_rd = 32'h0;
            else if (exp_ready[cyc]) cur_rd = exp_rd[cyc];
            check("ready",     {31'b0, Ready},  {31'b0, exp_ready[cyc]});
            check("bus_err",   {31'b0, BusErr}, {31'b0, exp_err[cyc]});
            check("rom_en",    {31'b0, rom_en}, {31'b0, exp_rom[cyc]});
            check("ram_en",    {31'b0, ram_en}, {31'b0, exp_ram[cyc]});
            check("ram_we",    {31'b0, ram_we}, {31'b0, exp_we[cyc]});
            check("read_data", ReadData, cur_rd);
            if (exp_rom[cyc]) check("rom_addr", {21'b0, rom_addr}, exp_addr[cyc]);
            if (exp_ram[cyc]) check("ram_addr", {22'b0, ram_addr}, exp_addr[cyc]);
            if (exp_we[cyc]) begin
                check("ram_be",    {28'b0, ram_be}, {28'b0, exp_be[cyc]});
                check("ram_wdata", ram_wdata, exp_wd[cyc]);
            end
        end
    end

    // One bus transaction: the model derives error/latency/word address from the memory map,
    // schedules expected outputs by absolute cycle, and lit_* pin the model to hand values.
    task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic rcs, input logic rwe, input logic ocs,
                       input logic [31:0] rd, input logic keep, input logic abort,
                       input int lit_wa, input int lit_lat, input logic lit_err);
        logic err;
        int   w;
        int   lat;
        int   wa;
        int   c0;
        err = (rcs == ocs) || (ocs && wr);
`ifdef MISALIGN_CHECK_EN
        if (a[1:0] != 2'b00) err = 1'b1;
`endif
        w   = ocs ? ROM_WAIT : RAM_WAIT;
        lat = err ? 1 : w + 2;
        wa  = ocs ? int'((a >> 2) % 2048) : int'(((a - 32'h2000) >> 2) % 1024);
        check("lit_err", {31'b0, err}, {31'b0, lit_err});
        check("lit_lat", lat, lit_lat);
        if (lit_wa >= 0) check("lit_wa", wa, lit_wa);

        Req = 1'b1; MemWrite = wr; Addr = a; WriteData = wd; ByteEn = be;
        RAM_CS = rcs; RAM_WE = rwe; ROM_CS = ocs;
        rom_rdata = ocs ? rd : ~rd;
        ram_rdata = ocs ? ~rd : rd;
        c0 = cyc;
        if (!abort) begin
            if (!err) begin
                if (ocs) begin
                    exp_rom[c0+1+w]  = 1'b1;
                    exp_addr[c0+1+w] = wa;
                end else if (!(wr && be == 4'b0)) begin
                    exp_ram[c0+1+w]  = 1'b1;
                    exp_addr[c0+1+w] = wa;
                    exp_we[c0+1+w]   = wr & rwe;
                    exp_be[c0+1+w]   = be;
                    exp_wd[c0+1+w]   = wd;
                end
            end
            exp_ready[c0+lat] = 1'b1;
            exp_err[c0+lat]   = err;
            exp_rd[c0+lat]    = err ? 32'h0 : (wr ? model_last : rd);
            model_last        = exp_rd[c0+lat];
        end

        @(posedge clk); #2;
        // Inputs wander while the transaction is in flight; only Req stays up.
        Addr = ~a; WriteData = ~wd; ByteEn = ~be; MemWrite = ~wr;
        RAM_CS = ~rcs; RAM_WE = ~rwe; ROM_CS = ~ocs;
        if (!abort) begin
            repeat (lat) @(posedge clk);
            #2;
            if (!keep) Req = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; Req = 1'b0; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
        ByteEn = 4'h0; RAM_CS = 1'b0; RAM_WE = 1'b0; ROM_CS = 1'b0;
        rom_rdata = 32'h0; ram_rdata = 32'h0;
        idle(3);
        check("rst_ready",     {31'b0, Ready},  32'h0);
        check("rst_read_data", ReadData,        32'h0);
        check("rst_bus_err",   {31'b0, BusErr}, 32'h0);
        check("rst_rom_en",    {31'b0, rom_en}, 32'h0);
        check("rst_rom_addr",  {21'b0, rom_addr}, 32'h0);
        check("rst_ram_en",    {31'b0, ram_en}, 32'h0);
        check("rst_ram_we",    {31'b0, ram_we}, 32'h0);
        check("rst_ram_be",    {28'b0, ram_be}, 32'h0);
        check("rst_ram_addr",  {22'b0, ram_addr}, 32'h0);
        check("rst_ram_wdata", ram_wdata,       32'h0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        idle(1);

        //  wr    addr          wdata         be       rcs   rwe   ocs   rdata         keep  abort wa     lat err
        txn(1'b0, 32'h0000_2004, 32'h0,        4'h0,    1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1,     2,  1'b0);
        idle(1);
        txn(1'b0, 32'h0000_0010, 32'h0,        4'h0,    1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 4,     4,  1'b0);
        idle(1);
        txn(1'b1, 32'h0000_2FFC, 32'hA5A5A5A5, 4'b0011, 1'b1, 1'b1, 1'b0, 32'h0BAD0001, 1'b0, 1'b0, 10'h3FF, 2, 1'b0);
        check("write_keeps_read_data", ReadData, 32'h12345678);
        idle(1);
        txn(1'b1, 32'h0000_0100, 32'h11112222, 4'hF,    1'b0, 1'b0, 1'b1, 32'h0BAD0002, 1'b0, 1'b0, -1,    1,  1'b1);
        idle(1);
        txn(1'b0, 32'h0000_4000, 32'h0,        4'h0,    1'b0, 1'b0, 1'b0, 32'h0BAD0003, 1'b0, 1'b0, -1,    1,  1'b1);
        idle(1);
        txn(1'b0, 32'h0000_2010, 32'h0,        4'h0,    1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4,     2,  1'b0);
        idle(1);
`ifdef MISALIGN_CHECK_EN
        txn(1'b0, 32'h0000_2002, 32'h0,        4'h0,    1'b1, 1'b0, 1'b0, 32'h600DD00D, 1'b0, 1'b0, 0,     1,  1'b1);
`else
        txn(1'b0, 32'h0000_2002, 32'h0,        4'h0,    1'b1, 1'b0, 1'b0, 32'h600DD00D, 1'b0, 1'b0, 0,     2,  1'b0);
`endif
        idle(1);
        txn(1'b1, 32'h0000_2040, 32'h77778888, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0BAD0004, 1'b0, 1'b0, 16,    2,  1'b0);
        idle(2);

        txn(1'b0, 32'h0000_0020, 32'h0,        4'h0,    1'b0, 1'b0, 1'b1, 32'h0BAD0005, 1'b0, 1'b1, 8,     4,  1'b0);
        rst_n = 1'b0;
        Req = 1'b0;
        model_last = 32'h0;
        idle(2);
        rst_n = 1'b1;
        check("post_reset_read_data", ReadData, 32'h0);
        idle(1);

        txn(1'b0, 32'h0000_2FF8, 32'h0,        4'h0,    1'b1, 1'b0, 1'b0, 32'h13579BDF, 1'b1, 1'b0, 10'h3FE, 2, 1'b0);
        txn(1'b0, 32'h0000_1FFC, 32'h0,        4'h0,    1'b0, 1'b0, 1'b1, 32'h2468ACE0, 1'b1, 1'b0, 11'h7FF, 4, 1'b0);
        txn(1'b1, 32'h0000_2000, 32'hF00DFACE, 4'b1100, 1'b1, 1'b1, 1'b0, 32'h0BAD0006, 1'b1, 1'b0, 0,     2,  1'b0);
        txn(1'b0, 32'h0000_3000, 32'h0,        4'h0,    1'b1, 1'b1, 1'b1, 32'h0BAD0007, 1'b1, 1'b0, -1,    1,  1'b1);
        txn(1'b0, 32'h0000_2008, 32'h0,        4'h0,    1'b1, 1'b0, 1'b0, 32'h89ABCDEF, 1'b0, 1'b0, 2,     2,  1'b0);
        idle(3);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
